// File: rtl/xor_irq_ctrl.sv
// ----------------------------------------------------------------------------
// xor_irq_ctrl
//
// Multi-channel XOR mismatch interrupt controller. Each of CHANNELS channels
// compares a pair of WIDTH-bit words bitwise. The compare counts only while
// the channel's read_strobe bit is high. If a mismatch lasts for PERSIST
// consecutive qualified samples, the channel sets a sticky status bit and
// captures the offending XOR pattern. The status bit can be masked from the
// interrupt and is cleared by writing 1 to irq_clear.
//
// A mismatch that continues after the status bit is set does not fire again.
// If a new event fires while status is still pending, the overrun bit is set
// and the first captured pattern is kept.
//
// Parameters:
//   WIDTH     bits per compared word
//   CHANNELS  number of independent compare channels (1..16)
//   PERSIST   consecutive qualified mismatches needed to fire (1..255)
//   SEL_W     width of the capture select; 2**SEL_W >= CHANNELS
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_1       operand A, channel i in bits [i*WIDTH +: WIDTH]
//   data_2       operand B, same packing
//   read_strobe  per-channel compare qualifier
//   irq_mask     1 = channel does not drive interrupt (status still updates)
//   irq_clear    write-1-to-clear for status and overrun
//   sel          channel whose capture register appears on cap_data
//   irq_status   sticky pending bits
//   irq_overrun  sticky: an event fired while status was already pending
//   cap_data     captured XOR pattern of channel sel (0 if sel >= CHANNELS)
//   interrupt    OR of (irq_status & ~irq_mask)
// ----------------------------------------------------------------------------
module xor_irq_ctrl #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int PERSIST  = 2,
   parameter int SEL_W    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS*WIDTH-1:0]    data_1,
   input  logic [CHANNELS*WIDTH-1:0]    data_2,
   input  logic [CHANNELS-1:0]          read_strobe,
   input  logic [CHANNELS-1:0]          irq_mask,
   input  logic [CHANNELS-1:0]          irq_clear,
   input  logic [SEL_W-1:0]             sel,
   output logic [CHANNELS-1:0]          irq_status,
   output logic [CHANNELS-1:0]          irq_overrun,
   output logic [WIDTH-1:0]             cap_data,
   output logic                         interrupt
);

   // The counter must hold PERSIST itself. It never counts past PERSIST.
   localparam int CNT_W = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);

   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FIRE_AT  = CNT_W'(PERSIST - 1);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(PERSIST);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_FIRE,
      S_HOLD
   } state_t;

   logic [WIDTH-1:0] cap_all [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             status_q;
      logic             overrun_q;
      logic [WIDTH-1:0] cap_q;
      logic [WIDTH-1:0] diff;
      logic             qm;
      logic             fire;

      assign diff = data_1[i*WIDTH +: WIDTH] ^ data_2[i*WIDTH +: WIDTH];
      assign qm   = read_strobe[i] & (|diff);

      // fire is high on the edge that moves the FSM into S_FIRE. That edge
      // is the PERSIST-th consecutive qualified mismatch sample.
      // NOTE: combinational blocks assign a default before any branch, so no
      // path can leave the output unassigned and infer a latch.
      always_comb begin
         fire = 1'b0;
         case (state_q)
            S_IDLE:  fire = qm && (PERSIST == 1);
            S_COUNT: fire = qm && (cnt_q == CNT_FIRE_AT);
            default: fire = 1'b0;
         endcase
      end

      // NOTE: all state here uses non-blocking assignments. Every register
      // therefore updates from values sampled at the same edge, whatever
      // order the statements appear in.
      // NOTE: the capture registers are reset along with the control state.
      // cap_data then reads back 0 after reset, not garbage.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            status_q  <= 1'b0;
            overrun_q <= 1'b0;
            cap_q     <= '0;
         end else begin
            // Persistence FSM. irq_clear has no effect on it.
            case (state_q)
               S_IDLE: begin
                  if (qm) begin
                     cnt_q   <= (PERSIST == 1) ? CNT_SAT : CNT_ONE;
                     state_q <= fire ? S_FIRE : S_COUNT;
                  end
               end
               S_COUNT: begin
                  if (!qm) begin
                     // The run is broken: a strobe drop counts the same as
                     // a match.
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                     if (fire) begin
                        state_q <= S_FIRE;
                     end
                  end
               end
               S_FIRE: begin
                  if (qm) begin
                     state_q <= S_HOLD;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end
               end
               S_HOLD: begin
                  // A continuing mismatch stays here and does not fire again.
                  if (!qm) begin
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            endcase

            // Status, overrun and capture. When a fire and a clear land on
            // the same edge, the fire wins. The clear still removes the old
            // pending event, so the new pattern is captured and overrun
            // is not raised.
            if (fire) begin
               status_q <= 1'b1;
               if (status_q && !irq_clear[i]) begin
                  overrun_q <= 1'b1;
               end else begin
                  cap_q <= diff;
                  if (irq_clear[i]) begin
                     overrun_q <= 1'b0;
                  end
               end
            end else if (irq_clear[i]) begin
               status_q  <= 1'b0;
               overrun_q <= 1'b0;
            end
         end
      end

      assign irq_status[i]  = status_q;
      assign irq_overrun[i] = overrun_q;
      assign cap_all[i]     = cap_q;
   end

   // Capture readback. A select value with no matching channel reads as 0.
   always_comb begin
      cap_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) begin
            cap_data = cap_all[k];
         end
      end
   end

   // Masking acts only here, so a mask change is seen on interrupt at once.
   assign interrupt = |(irq_status & ~irq_mask);

endmodule
